// File: rtl/risc_mem_pkg.sv
// Shared definitions for the RISC memory responder: state encoding,
// default I/O register addresses and the data width.
package risc_mem_pkg;

  localparam int DATA_W = 16;

  localparam logic [15:0] IO_OUT_ADR_DEF = 16'hFFF0;
  localparam logic [15:0] IO_IN_ADR_DEF  = 16'hFFF1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/risc_ram_sp.sv
// Single-port word RAM: synchronous write, asynchronous read on the same
// address, so a read during a write returns the old word until the edge.
module risc_ram_sp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/risc_mem_responder.sv
// Memory-side responder for the RISC CPU: boot-loads program words into RAM
// while holding the CPU in reset, then serves RAM and two I/O registers.
//
// Loader handshake: a boot word transfers on every rising edge where
// ld_valid and ld_ready are both high; ld_ready is high only in LOAD and
// never depends on ld_valid, and the sender holds data stable until taken.
module risc_mem_responder
  import risc_mem_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter logic [15:0] IO_OUT_ADR = IO_OUT_ADR_DEF,
  parameter logic [15:0] IO_IN_ADR  = IO_IN_ADR_DEF,
  parameter bit          SKIP_LOAD  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_addr,
  input  logic [15:0]       cpu_wdata,
  input  logic              mw_en,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_run,
  input  logic              ld_valid,
  input  logic [15:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [15:0]       io_in,
  output logic [15:0]       io_out,
  output logic              acc_err,
  output state_t            dbg_state,
  output logic [ADDR_W-1:0] dbg_ld_ptr
);

  localparam state_t            RST_STATE = SKIP_LOAD ? ST_RUN : ST_LOAD;
  localparam logic [ADDR_W-1:0] PTR_MAX   = '1;

  state_t            state_q, state_next;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_next;
  logic [15:0]       io_out_q;
  logic              acc_err_q;
  logic [15:0]       sync1_q, sync2_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;

  logic              is_out, is_in, in_ram, unmapped;
  logic              io_out_we, err_set;

  // I/O addresses take priority over RAM in case a wide RAM overlaps them.
  assign is_out   = (cpu_addr == IO_OUT_ADR);
  assign is_in    = (cpu_addr == IO_IN_ADR);
  assign in_ram   = ((cpu_addr >> ADDR_W) == 16'd0);
  assign unmapped = !(is_out || is_in || in_ram);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RST_STATE;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next  = state_q;
    ld_ptr_next = ld_ptr_q;
    cpu_run     = 1'b0;
    ld_ready    = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = cpu_addr[ADDR_W-1:0];
    ram_wdata   = cpu_wdata;
    cpu_rdata   = 16'h0000;
    io_out_we   = 1'b0;
    err_set     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ld_ready  = reset;
        ram_addr  = ld_ptr_q;
        ram_wdata = ld_data;
        if (ld_valid && reset) begin
          ram_we      = 1'b1;
          ld_ptr_next = ld_ptr_q + 1'b1;
          if (ld_last || ld_ptr_q == PTR_MAX) state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        cpu_run = 1'b1;
        if (is_out)      cpu_rdata = io_out_q;
        else if (is_in)  cpu_rdata = sync2_q;
        else if (in_ram) cpu_rdata = ram_rdata;
        // Any run-time access to an unmapped address, read or write, is an error.
        err_set = unmapped;
        if (mw_en) begin
          ram_we    = in_ram && !is_out && !is_in;
          io_out_we = is_out;
        end
      end
      default: state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_ptr_q  <= '0;
      io_out_q  <= 16'h0000;
      acc_err_q <= 1'b0;
      sync1_q   <= 16'h0000;
      sync2_q   <= 16'h0000;
    end else begin
      ld_ptr_q <= ld_ptr_next;
      if (io_out_we) io_out_q  <= cpu_wdata;
      if (err_set)   acc_err_q <= 1'b1;
      sync1_q <= io_in;
      sync2_q <= sync1_q;
    end
  end

  risc_ram_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign io_out     = io_out_q;
  assign acc_err    = acc_err_q;
  assign dbg_state  = state_q;
  assign dbg_ld_ptr = ld_ptr_q;

endmodule
